// File: rtl/out_bcd_display_if.sv
// Handshake and display bus for the BCD display stage.
// The master drives the conversion request; the slave returns the status,
// the BCD digits and the seven-segment codes.
interface out_bcd_display_if;
   logic        start;
   logic [7:0]  value;
   logic        signed_mode;
   logic        busy;
   logic        done;
   logic [11:0] bcd;
   logic        negative;
   logic [6:0]  hex_sign;
   logic [6:0]  hex2;
   logic [6:0]  hex1;
   logic [6:0]  hex0;

   modport master (
      output start, value, signed_mode,
      input  busy, done, bcd, negative, hex_sign, hex2, hex1, hex0
   );

   modport slave (
      input  start, value, signed_mode,
      output busy, done, bcd, negative, hex_sign, hex2, hex1, hex0
   );
endinterface

// File: rtl/out_bcd_display.sv
// Binary-to-decimal display stage for the 8-bit output register.
// A start strobe captures the value (unsigned or two's complement), a
// double-dabble datapath converts the magnitude over eight cycles, and the
// result is registered as BCD plus four active-low seven-segment digits.
module out_bcd_display #(
   parameter bit BLANK_LZ = 1'b1
) (
   input logic              clk,
   input logic              reset,
   out_bcd_display_if.slave bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CONVERT = 2'd1;
   localparam logic [1:0] FINISH  = 2'd2;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   // With blanking on, the upper digits of a zero result are dark
   localparam logic [6:0] SEG_UPPER_RESET = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

   logic [1:0]  state;
   logic [7:0]  mag;
   logic        sign;
   logic [11:0] scratch;
   logic [2:0]  step;
   logic [11:0] adjusted;
   logic [6:0]  next_hex2;
   logic [6:0]  next_hex1;

   logic        done_q;
   logic [11:0] bcd_q;
   logic        negative_q;
   logic [6:0]  hex_sign_q;
   logic [6:0]  hex2_q;
   logic [6:0]  hex1_q;
   logic [6:0]  hex0_q;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Add-3 correction of every scratch digit before the shift
   always_comb begin
      adjusted = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
   end

   // Upper digit segments with optional leading-zero blanking
   always_comb begin
      next_hex2 = seg_code(scratch[11:8]);
      next_hex1 = seg_code(scratch[7:4]);
      if (BLANK_LZ) begin
         if (scratch[11:8] == 4'd0)
            next_hex2 = SEG_BLANK;
         if (scratch[11:8] == 4'd0 && scratch[7:4] == 4'd0)
            next_hex1 = SEG_BLANK;
      end
   end

   // Control FSM and double-dabble datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         mag     <= 8'd0;
         sign    <= 1'b0;
         scratch <= 12'd0;
         step    <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.signed_mode && bus.value[7]) begin
                     mag  <= ~bus.value + 8'd1;
                     sign <= 1'b1;
                  end else begin
                     mag  <= bus.value;
                     sign <= 1'b0;
                  end
                  scratch <= 12'd0;
                  step    <= 3'd0;
                  state   <= CONVERT;
               end
            end
            CONVERT: begin
               scratch <= {adjusted[10:0], mag[7]};
               mag     <= {mag[6:0], 1'b0};
               step    <= step + 3'd1;
               if (step == 3'd7)
                  state <= FINISH;
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Result registers, loaded only when a conversion completes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q     <= 1'b0;
         bcd_q      <= 12'd0;
         negative_q <= 1'b0;
         hex_sign_q <= SEG_BLANK;
         hex2_q     <= SEG_UPPER_RESET;
         hex1_q     <= SEG_UPPER_RESET;
         hex0_q     <= SEG_ZERO;
      end else begin
         done_q <= 1'b0;
         if (state == FINISH) begin
            done_q     <= 1'b1;
            bcd_q      <= scratch;
            negative_q <= sign;
            hex_sign_q <= sign ? SEG_MINUS : SEG_BLANK;
            hex2_q     <= next_hex2;
            hex1_q     <= next_hex1;
            hex0_q     <= seg_code(scratch[3:0]);
         end
      end
   end

   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_q;
   assign bus.bcd      = bcd_q;
   assign bus.negative = negative_q;
   assign bus.hex_sign = hex_sign_q;
   assign bus.hex2     = hex2_q;
   assign bus.hex1     = hex1_q;
   assign bus.hex0     = hex0_q;

endmodule
